// File: rtl/npu_host_if.sv
// npu_host_if: Avalon-MM slave with the NPU control register and a host-to-loader word FIFO.
// Read data is registered (latency 1). DATA writes stall on waitrequest while the FIFO is full.

module npu_host_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [W-1:0]     dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     dat_o,
  output logic             vld_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [W-1:0]     hold_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign vld_o   = (level_q != '0);
  assign level_o = level_q;
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & vld_o & ~clr_i;

  // Show-ahead head; once empty, keep presenting the last word seen rather than stale RAM.
  assign dat_o = vld_o ? mem_q[rd_ptr_q] : hold_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= dat_o;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end

endmodule

module npu_host_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] control_reg,
  output logic [31:0] load_data,
  output logic        load_valid,
  input  logic        load_ready,
  output logic        fifo_overrun
);

  localparam logic [2:0] ADDR_CONTROL = 3'd0;
  localparam logic [2:0] ADDR_DATA    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;
  localparam logic [2:0] ADDR_CLEAR   = 3'd4;

  logic             sel_wr, sel_rd;
  logic             wr_ctrl, wr_data, wr_clr;
  logic             flush, push, pop;
  logic             full, empty;
  logic [LVL_W-1:0] level;
  logic [31:0]      status_word;

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ovr_q, ovr_d;

  assign sel_wr  = chipselect & write;
  assign sel_rd  = chipselect & read;
  assign wr_ctrl = sel_wr & (address == ADDR_CONTROL);
  assign wr_data = sel_wr & (address == ADDR_DATA);
  assign wr_clr  = sel_wr & (address == ADDR_CLEAR);

  // Flush wins over a concurrent pop: the popped word is dropped and not counted.
  assign flush = wr_ctrl & writedata[31];
  assign push  = wr_data & ~full;
  assign pop   = load_valid & load_ready & ~flush;
  assign empty = ~load_valid;

  assign waitrequest  = wr_data & full;
  assign readdata     = rdata_q;
  assign control_reg  = ctrl_q;
  assign fifo_overrun = ovr_q;
  assign status_word  = {16'h0, 8'(level), 5'h0, ovr_q, full, empty};

  npu_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (flush),
    .push_i  (push),
    .dat_i   (writedata),
    .pop_i   (pop),
    .dat_o   (load_data),
    .vld_o   (load_valid),
    .full_o  (full),
    .level_o (level)
  );

  always_comb begin
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    rdata_d = rdata_q;

    if (wr_ctrl) ctrl_d = {1'b0, writedata[30:0]};

    if (flush)    cnt_d = '0;
    else if (pop) cnt_d = cnt_q + 32'd1;

    // A rejected DATA write sets the sticky flag even if a clear lands the same cycle.
    if (waitrequest)                  ovr_d = 1'b1;
    else if (wr_clr && writedata[0])  ovr_d = 1'b0;

    if (sel_rd) begin
      case (address)
        ADDR_CONTROL: rdata_d = ctrl_q;
        ADDR_STATUS:  rdata_d = status_word;
        ADDR_COUNT:   rdata_d = cnt_q;
        default:      rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_npu_host_if.sv
// Self-checking bench for npu_host_if: scoreboard of loader words plus register read checks.
module tb_npu_host_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] control_reg;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        fifo_overrun;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  npu_host_if #(.FIFO_DEPTH(16), .LVL_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .address      (address),
    .write        (write),
    .read         (read),
    .writedata    (writedata),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .control_reg  (control_reg),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .fifo_overrun (fifo_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Loader-side scoreboard: every consumed word must match the oldest pushed word.
  logic flush_now;
  assign flush_now = chipselect && write && (address == 3'd0) && writedata[31];

  always @(negedge clk) begin
    if (!reset && load_valid && load_ready && !flush_now) begin
      if (exp_q.size() == 0) chk("pop_unexpected", load_data, 32'hDEAD_BEEF);
      else                   chk("load_data", load_data, exp_q.pop_front());
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic lr,
                           output int stalls);
    stalls = 0;
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; load_ready = lr;
    forever begin
      @(negedge clk);
      if (!waitrequest || stalls > 50) break;
      stalls++;
      @(posedge clk); #1;
    end
    chk("wr_accept", {31'h0, waitrequest}, 32'h0);
    if (a == 3'd1 && !waitrequest) exp_q.push_back(d);
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic drain();
    load_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'h0);
    chk("drain_valid", {31'h0, load_valid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          st;
    int          tot;
    logic [31:0] rd;

    reset = 1'b1; chipselect = 1'b0; address = '0; write = 1'b0; read = 1'b0;
    writedata = '0; load_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ctrl",  control_reg, 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_ovr",   {31'h0, fifo_overrun}, 32'h0);
    chk("rst_wait",  {31'h0, waitrequest}, 32'h0);

    // Control write and empty status
    bus_write(3'd0, 32'h1, 1'b0, st);
    chk("ctrl_1", control_reg, 32'h1);
    bus_read(3'd2, rd);
    chk("status_empty", rd, 32'h1);

    // Single word: valid one cycle after the push, then consumed
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'hA1B2_C3D4; load_ready = 1'b1;
    @(negedge clk);
    chk("single_wait", {31'h0, waitrequest}, 32'h0);
    chk("single_lat0", {31'h0, load_valid}, 32'h0);
    exp_q.push_back(32'hA1B2_C3D4);
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("single_lat1", {31'h0, load_valid}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_gone", {31'h0, load_valid}, 32'h0);
    chk("single_hold", load_data, 32'hA1B2_C3D4);
    bus_read(3'd3, rd);
    chk("count_1", rd, 32'd1);

    // Fill to full, overrun, then retry while draining
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      bus_write(3'd1, 32'h3000_0000 + 32'(i), 1'b0, st);
      tot += st;
    end
    chk("fill_stalls", 32'(tot), 32'h0);
    bus_read(3'd2, rd);
    chk("status_full", rd, 32'h0000_1002);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'h3000_0010;
    @(negedge clk);
    chk("full_wait", {31'h0, waitrequest}, 32'h1);
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("ovr_set", {31'h0, fifo_overrun}, 32'h1);
    bus_read(3'd2, rd);
    chk("status_ovr", rd, 32'h0000_1006);
    bus_write(3'd1, 32'h3000_0010, 1'b1, st);
    chk("retry_stalls", 32'(st), 32'd1);
    drain();
    bus_read(3'd3, rd);
    chk("count_18", rd, 32'd18);
    bus_read(3'd2, rd);
    chk("status_ovr_empty", rd, 32'h5);
    bus_write(3'd4, 32'h1, 1'b0, st);
    bus_read(3'd2, rd);
    chk("ovr_cleared", rd, 32'h1);

    // Level 8, then 10 cycles of simultaneous push and pop
    for (int i = 0; i < 8; i++) bus_write(3'd1, 32'h4000_0000 + 32'(i), 1'b0, st);
    bus_read(3'd2, rd);
    chk("status_lvl8", rd, 32'h0000_0800);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = 3'd1; load_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      writedata = 32'h4100_0000 + 32'(i);
      @(negedge clk);
      chk("stream_wait", {31'h0, waitrequest}, 32'h0);
      exp_q.push_back(writedata);
      @(posedge clk); #1;
    end
    chipselect = 1'b0; write = 1'b0; load_ready = 1'b0;
    bus_read(3'd2, rd);
    chk("stream_lvl8", rd, 32'h0000_0800);
    drain();
    bus_read(3'd3, rd);
    chk("count_36", rd, 32'd36);

    // Flush with a pop offered in the same cycle
    load_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(3'd1, 32'h5000_0000 + 32'(i), 1'b0, st);
    bus_write(3'd0, 32'h8000_0001, 1'b1, st);
    exp_q.delete();
    @(negedge clk);
    chk("flush_ctrl",  control_reg, 32'h1);
    chk("flush_valid", {31'h0, load_valid}, 32'h0);
    chk("flush_hold",  load_data, 32'h5000_0000);
    bus_read(3'd2, rd);
    chk("flush_status", rd, 32'h1);
    bus_read(3'd3, rd);
    chk("flush_count", rd, 32'h0);

    // Ignored writes and undefined reads
    bus_write(3'd2, 32'hFFFF_FFFF, 1'b0, st);
    bus_write(3'd3, 32'hFFFF_FFFF, 1'b0, st);
    bus_write(3'd6, 32'hFFFF_FFFF, 1'b0, st);
    bus_read(3'd0, rd);
    chk("read_ctrl", rd, 32'h1);
    bus_read(3'd7, rd);
    chk("read_undef", rd, 32'h0);
    bus_read(3'd3, rd);
    chk("count_ro", rd, 32'h0);
    bus_read(3'd2, rd);
    chk("status_ro", rd, 32'h1);

    // Reset mid-transfer
    bus_write(3'd0, 32'h55, 1'b0, st);
    bus_read(3'd0, rd);
    chk("ctrl_55", rd, 32'h55);
    for (int i = 0; i < 3; i++) bus_write(3'd1, 32'h6000_0000 + 32'(i), 1'b0, st);
    @(posedge clk); #1;
    reset = 1'b1; load_ready = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'h6000_0003;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_ctrl",  control_reg, 32'h0);
    chk("mid_rst_rdata", readdata, 32'h0);
    chk("mid_rst_valid", {31'h0, load_valid}, 32'h0);
    chk("mid_rst_ldata", load_data, 32'h0);
    chk("mid_rst_ovr",   {31'h0, fifo_overrun}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_read(3'd2, rd);
    chk("post_rst_status", rd, 32'h1);
    bus_read(3'd3, rd);
    chk("post_rst_count", rd, 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
